window_sum_tracker: RTL and testbench

Consumer stage placed directly downstream of the 5-deep, 8-bit delay line. It receives each sample as it enters the delay line (new_sample) and the 5-cycle-delayed sample leaving it (old_sample), and keeps a running sum of the last DEPTH samples in O(1) per cycle (sum += new - old). It also flags threshold crossings, tracks the peak windowed sum, and counts above-threshold cycles for the experiment display logic.

---
 rtl/window_sum_tracker_pkg.sv | 14 +
 rtl/window_sum_tracker_if.sv | 25 ++
 rtl/window_sum_tracker_sat_counter.sv | 26 ++
 rtl/window_sum_tracker.sv | 97 +++++++++
 tb/tb_window_sum_tracker.sv | 155 +++++++++++++++
 5 files changed

// File: rtl/window_sum_tracker_pkg.sv
// Shared constants and state encoding for the windowed-sum consumer and its delay line.
package window_sum_tracker_pkg;

  localparam int WIDTH = 8;
  localparam int DEPTH = 5;
  localparam int SUM_W = 11;
  localparam int CNT_W = 8;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/window_sum_tracker_if.sv
// Sample, control and result signals between the delay-line side and the window tracker.
interface window_sum_tracker_if;
  import window_sum_tracker_pkg::*;

  logic [WIDTH-1:0] new_sample;
  logic [WIDTH-1:0] old_sample;
  logic             clr;
  logic [SUM_W-1:0] threshold;
  logic [SUM_W-1:0] sum;
  logic             sum_valid;
  logic             above_thresh;
  logic [SUM_W-1:0] peak_sum;
  logic [CNT_W-1:0] over_count;

  modport master (
    output new_sample, old_sample, clr, threshold,
    input  sum, sum_valid, above_thresh, peak_sum, over_count
  );

  modport slave (
    input  new_sample, old_sample, clr, threshold,
    output sum, sum_valid, above_thresh, peak_sum, over_count
  );

endinterface

// File: rtl/window_sum_tracker_sat_counter.sv
// Up-counter with enable and synchronous clear that sticks at its all-ones value.
module window_sum_tracker_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] q
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (en && (count_reg != '1)) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign q = count_reg;

endmodule

// File: rtl/window_sum_tracker.sv
// Running sum of the last DEPTH samples (sum += new - old) with threshold flag,
// peak tracking and a saturating above-threshold cycle counter.
module window_sum_tracker
  import window_sum_tracker_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  window_sum_tracker_if.slave  bus
);

  localparam int EXT_W = SUM_W + 1;
  localparam int FC_W  = $clog2(DEPTH + 1);
  localparam logic [FC_W-1:0] FILL_LAST = FC_W'(DEPTH);

  state_t           state_reg, state_next;
  logic [FC_W-1:0]  fill_cnt_reg, fill_cnt_next;
  logic [SUM_W-1:0] sum_reg, sum_next;
  logic [SUM_W-1:0] peak_reg, peak_next;
  logic             above_reg, above_next;
  logic             valid_next;
  logic [EXT_W-1:0] sum_ext;
  logic [CNT_W-1:0] over_count;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= FILL;
      fill_cnt_reg <= '0;
      sum_reg      <= '0;
      peak_reg     <= '0;
      above_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      fill_cnt_reg <= fill_cnt_next;
      sum_reg      <= sum_next;
      peak_reg     <= peak_next;
      above_reg    <= above_next;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_next    = state_reg;
    fill_cnt_next = fill_cnt_reg;
    sum_ext       = EXT_W'(sum_reg) + EXT_W'(bus.new_sample);
    if (bus.clr) begin
      // Restart the window from this sample; the delay line still holds old data.
      sum_ext       = EXT_W'(bus.new_sample);
      fill_cnt_next = FC_W'(1);
      state_next    = (DEPTH == 1) ? RUN : FILL;
    end else begin
      case (state_reg)
        FILL: begin
          fill_cnt_next = fill_cnt_reg + 1'b1;
          if ((fill_cnt_reg + 1'b1) == FILL_LAST) begin
            state_next = RUN;
          end
        end
        RUN: begin
          sum_ext = EXT_W'(sum_reg) + EXT_W'(bus.new_sample) - EXT_W'(bus.old_sample);
        end
        default: state_next = FILL;
      endcase
    end

    sum_next   = SUM_W'(sum_ext);
    valid_next = (state_next == RUN);
    above_next = !bus.clr && valid_next && (sum_next >= bus.threshold);

    peak_next = peak_reg;
    if (bus.clr) begin
      peak_next = '0;
    end else if (valid_next && (sum_next > peak_reg)) begin
      peak_next = sum_next;
    end
  end

  window_sum_tracker_sat_counter #(
    .W (CNT_W)
  ) u_over_cnt (
    .clk (clk),
    .rst (rst),
    .en  (above_next),
    .clr (bus.clr),
    .q   (over_count)
  );

  // Outputs
  always_comb begin
    bus.sum          = sum_reg;
    bus.sum_valid    = (state_reg == RUN);
    bus.above_thresh = above_reg;
    bus.peak_sum     = peak_reg;
    bus.over_count   = over_count;
  end

endmodule

// File: tb/tb_window_sum_tracker.sv
// Scoreboard bench: a reference window model predicts each edge's outputs.
module tb_window_sum_tracker;
  import window_sum_tracker_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  window_sum_tracker_if bus();

  window_sum_tracker dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    int unsigned sum;
    bit          valid;
    bit          above;
    int unsigned peak;
    int unsigned over;
  } exp_t;

  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

  exp_t        sb[$];
  int unsigned win[$];
  int unsigned dl[$];
  int unsigned m_cnt, m_peak, m_over;
  int unsigned thr;
  int          checks = 0;
  int          failures = 0;
  int          n_step = 0;

  task automatic check_val(input string tag, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    win.delete();
    m_cnt  = 0;
    m_peak = 0;
    m_over = 0;
    dl = '{0, 0, 0, 0, 0};
  endtask

  task automatic step(input int unsigned ns, input bit c);
    exp_t        e;
    exp_t        got;
    int unsigned s;
    @(negedge clk);
    bus.new_sample = WIDTH'(ns);
    bus.old_sample = WIDTH'(dl[0]);
    bus.clr        = c;
    bus.threshold  = SUM_W'(thr);
    if (c) begin
      win.delete();
      m_cnt  = 0;
      m_peak = 0;
      m_over = 0;
    end
    win.push_back(ns);
    if (win.size() > DEPTH) void'(win.pop_front());
    if (m_cnt < DEPTH) m_cnt++;
    s = 0;
    foreach (win[i]) s += win[i];
    e.sum   = s;
    e.valid = (m_cnt >= DEPTH);
    e.above = !c && e.valid && (s >= thr);
    if (e.valid && s > m_peak) m_peak = s;
    if (e.above && m_over < CNT_MAX) m_over++;
    e.peak = m_peak;
    e.over = m_over;
    sb.push_back(e);

    @(posedge clk);
    #1;
    dl.push_back(ns);
    void'(dl.pop_front());
    bus.clr = 1'b0;
    got = sb.pop_front();
    check_val($sformatf("sum[%0d]", n_step), bus.sum, got.sum);
    check_val($sformatf("sum_valid[%0d]", n_step), bus.sum_valid, got.valid);
    check_val($sformatf("above_thresh[%0d]", n_step), bus.above_thresh, got.above);
    check_val($sformatf("peak_sum[%0d]", n_step), bus.peak_sum, got.peak);
    check_val($sformatf("over_count[%0d]", n_step), bus.over_count, got.over);
    $display("step %0d new=%0d clr=%0d thr=%0d sum=%0d valid=%0d above=%0d peak=%0d over=%0d",
             n_step, ns, c, thr, bus.sum, bus.sum_valid, bus.above_thresh,
             bus.peak_sum, bus.over_count);
    n_step++;
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, "_sum"}, bus.sum, 0);
    check_val({tag, "_sum_valid"}, bus.sum_valid, 0);
    check_val({tag, "_above_thresh"}, bus.above_thresh, 0);
    check_val({tag, "_peak_sum"}, bus.peak_sum, 0);
    check_val({tag, "_over_count"}, bus.over_count, 0);
  endtask

  // Drop reset between edges, confirm the outputs clear at once, release before the next edge.
  task automatic async_reset(input string tag);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_zero(tag);
    $display("async reset %s applied", tag);
    model_reset();
    #1;
    rst = 1'b1;
  endtask

  initial begin
    rst            = 1'b0;
    bus.new_sample = '0;
    bus.old_sample = '0;
    bus.clr        = 1'b0;
    thr            = 200;
    bus.threshold  = SUM_W'(thr);
    model_reset();

    #12;
    check_zero("reset");
    @(posedge clk);
    #2;
    rst = 1'b1;

    for (int i = 1; i <= 7; i++) step(i * 10, 1'b0);

    step(7, 1'b1);
    for (int i = 0; i < 4; i++) step(1, 1'b0);

    step(80, 1'b0);
    step(90, 1'b0);
    async_reset("rst_mid_run");

    for (int i = 0; i < 8; i++) step(255, 1'b0);

    async_reset("rst_full");
    for (int i = 0; i < 5; i++) step(100, 1'b0);

    thr = 0;
    for (int i = 0; i < 300; i++) step($urandom_range(0, 255), 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
